// File: rtl/stage_seq_pkg.sv
// Shared definitions for the multi-cycle stage sequencer: the 3-bit state
// encoding and the width of the EX latency counter.
package stage_seq_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALT      = 3'd6
  } state_e;

endpackage

// File: rtl/ex_latency_counter.sv
// EX-stage latency counter: loaded in DECODE with the instruction's EX
// cycle count, decremented each EX cycle; last_o marks the final EX cycle.
module ex_latency_counter
  import stage_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             dec_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             last_o,
  output logic             busy_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Load takes precedence; decrement saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == CNT_W'(1));
  assign busy_o = (cnt_q > CNT_W'(1));

endmodule

// File: rtl/stage_sequencer.sv
// Multi-cycle control FSM stepping the datapath through fetch, decode,
// execute, memory and writeback, with imem/dmem ready handshakes and
// multi-cycle EX holds for mul/div/mod.
// Optional performance counters (retired_cnt, stall_cnt) are built when the
// macro STAGE_SEQ_PERF_EN is defined.
module stage_sequencer
  import stage_seq_pkg::*;
#(
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 8,
  parameter int ALU_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  input  logic        isLd,
  input  logic        isSt,
  input  logic        isWb,
  input  logic        isMul,
  input  logic        isDiv,
  input  logic        isMod,
  input  logic        halt_req,
  output logic        imem_req,
  output logic        ir_en,
  output logic        of_en,
  output logic        ex_en,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        rf_we,
  output logic        pc_en,
  output logic        halted,
  output logic [2:0]  state
`ifdef STAGE_SEQ_PERF_EN
  ,
  output logic [31:0] retired_cnt,
  output logic [31:0] stall_cnt
`endif
);

  state_e           state_q, state_d;
  logic             ld_q, st_q, wb_q;
  logic             cnt_load, cnt_dec, cnt_last, cnt_busy;
  logic [CNT_W-1:0] lat_sel;
  logic             complete;

  // EX latency selection with priority mul > div/mod > everything else.
  always_comb begin
    if (isMul) begin
      lat_sel = CNT_W'(MUL_LAT);
    end else if (isDiv || isMod) begin
      lat_sel = CNT_W'(DIV_LAT);
    end else begin
      lat_sel = CNT_W'(ALU_LAT);
    end
  end

  ex_latency_counter u_cnt (
    .clk        (clk),
    .rst        (reset),
    .load_i     (cnt_load),
    .dec_i      (cnt_dec),
    .load_val_i (lat_sel),
    .last_o     (cnt_last),
    .busy_o     (cnt_busy)
  );

  // Next-state and strobe decode; completion raises pc_en in the same cycle.
  always_comb begin
    state_d  = state_q;
    imem_req = 1'b0;
    ir_en    = 1'b0;
    of_en    = 1'b0;
    ex_en    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    pc_en    = 1'b0;
    halted   = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    complete = 1'b0;
    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        ir_en    = imem_ready;
        if (imem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        of_en    = 1'b1;
        cnt_load = 1'b1;
        state_d  = S_EXECUTE;
      end
      S_EXECUTE: begin
        ex_en   = 1'b1;
        cnt_dec = 1'b1;
        if (cnt_last) begin
          if (ld_q || st_q)  state_d = S_MEMORY;
          else if (wb_q)     state_d = S_WRITEBACK;
          else               complete = 1'b1;
        end
      end
      S_MEMORY: begin
        dmem_req = 1'b1;
        dmem_we  = st_q;
        if (dmem_ready) begin
          if (ld_q) state_d = S_WRITEBACK;
          else      complete = 1'b1;
        end
      end
      S_WRITEBACK: begin
        rf_we    = 1'b1;
        complete = 1'b1;
      end
      S_HALT: begin
        halted = 1'b1;
        if (!halt_req) state_d = S_FETCH;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (complete) begin
      pc_en   = 1'b1;
      state_d = halt_req ? S_HALT : S_FETCH;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Instruction-class flags captured in DECODE and held for the instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ld_q <= 1'b0;
      st_q <= 1'b0;
      wb_q <= 1'b0;
    end else if (state_q == S_DECODE) begin
      ld_q <= isLd;
      st_q <= isSt;
      wb_q <= isWb;
    end
  end

  assign state = state_q;

`ifdef STAGE_SEQ_PERF_EN
  logic [31:0] retired_q, stall_q;
  logic        stall_cyc;

  assign stall_cyc = ((state_q == S_FETCH)   && !imem_ready) ||
                     ((state_q == S_MEMORY)  && !dmem_ready) ||
                     ((state_q == S_EXECUTE) && cnt_busy);

  // Retired-instruction and stall-cycle counters, wrapping modulo 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired_q <= '0;
      stall_q   <= '0;
    end else begin
      if (pc_en)     retired_q <= retired_q + 32'd1;
      if (stall_cyc) stall_q   <= stall_q + 32'd1;
    end
  end

  assign retired_cnt = retired_q;
  assign stall_cnt   = stall_q;
`endif

endmodule

// File: tb/tb_stage_sequencer.sv
// Scoreboard bench for stage_sequencer: per-cycle input/expected-output
// pairs are queued from instruction timelines, then driven and compared.
module tb_stage_sequencer;

  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 8;
  localparam int ALU_LAT = 1;

  logic clk = 1'b0;
  logic reset;
  logic imem_ready, dmem_ready, isLd, isSt, isWb, isMul, isDiv, isMod, halt_req;
  logic imem_req, ir_en, of_en, ex_en, dmem_req, dmem_we, rf_we, pc_en, halted;
  logic [2:0] state;
`ifdef STAGE_SEQ_PERF_EN
  logic [31:0] retired_cnt, stall_cnt;
`endif

  stage_sequencer #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT),
    .ALU_LAT (ALU_LAT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_ready (imem_ready),
    .dmem_ready (dmem_ready),
    .isLd       (isLd),
    .isSt       (isSt),
    .isWb       (isWb),
    .isMul      (isMul),
    .isDiv      (isDiv),
    .isMod      (isMod),
    .halt_req   (halt_req),
    .imem_req   (imem_req),
    .ir_en      (ir_en),
    .of_en      (of_en),
    .ex_en      (ex_en),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .rf_we      (rf_we),
    .pc_en      (pc_en),
    .halted     (halted),
    .state      (state)
`ifdef STAGE_SEQ_PERF_EN
    ,
    .retired_cnt (retired_cnt),
    .stall_cnt   (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic imem_ready;
    logic dmem_ready;
    logic halt_req;
    logic ld;
    logic st;
    logic wb;
    logic mul;
    logic dv;
    logic md;
  } in_t;

  in_t         stim_q[$];
  logic [11:0] exp_q[$];
  int          n_cmp = 0;
  int          n_mis = 0;
  int          exp_retired = 0;
  int          exp_stall = 0;

  logic [11:0] dut_vec;
  assign dut_vec = {imem_req, ir_en, of_en, ex_en, dmem_req, dmem_we,
                    rf_we, pc_en, halted, state};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] ov(input bit imr, irn, ofn, exn, dmr, dmw, rfw, pcn, hlt,
                                     input logic [2:0] s);
    return {imr, irn, ofn, exn, dmr, dmw, rfw, pcn, hlt, s};
  endfunction

  function automatic in_t rnd(input bit noise);
    logic [8:0] r;
    r = noise ? 9'($urandom) : 9'd0;
    return in_t'(r);
  endfunction

  task automatic push(input in_t b, input logic [11:0] e);
    stim_q.push_back(b);
    exp_q.push_back(e);
  endtask

  task automatic apply(input in_t b);
    imem_ready = b.imem_ready;
    dmem_ready = b.dmem_ready;
    halt_req   = b.halt_req;
    isLd       = b.ld;
    isSt       = b.st;
    isWb       = b.wb;
    isMul      = b.mul;
    isDiv      = b.dv;
    isMod      = b.md;
  endtask

  // Queue one instruction's cycle-by-cycle timeline.
  task automatic gen(input bit ld, st, wb, mul, dv, md, input int ifs, dms,
                     input bit halt, noise);
    in_t b;
    int  lat;
    bit  done;
    lat = mul ? MUL_LAT : ((dv || md) ? DIV_LAT : ALU_LAT);
    for (int i = 0; i < ifs; i++) begin
      b = rnd(noise); b.imem_ready = 1'b0;
      push(b, ov(1, 0, 0, 0, 0, 0, 0, 0, 0, 3'd1));
    end
    b = rnd(noise); b.imem_ready = 1'b1;
    push(b, ov(1, 1, 0, 0, 0, 0, 0, 0, 0, 3'd1));
    b = rnd(noise);
    b.ld = ld; b.st = st; b.wb = wb; b.mul = mul; b.dv = dv; b.md = md;
    push(b, ov(0, 0, 1, 0, 0, 0, 0, 0, 0, 3'd2));
    for (int i = 0; i < lat; i++) begin
      b = rnd(noise);
      done = (i == lat - 1) && !(ld || st || wb);
      if (halt || done) b.halt_req = halt;
      push(b, ov(0, 0, 0, 1, 0, 0, 0, done, 0, 3'd3));
    end
    if (ld || st) begin
      for (int i = 0; i <= dms; i++) begin
        b = rnd(noise);
        b.dmem_ready = (i == dms);
        done = (i == dms) && !ld;
        if (halt || done) b.halt_req = halt;
        push(b, ov(0, 0, 0, 0, 1, st, 0, done, 0, 3'd4));
      end
    end
    if (ld || (!st && wb)) begin
      b = rnd(noise); b.halt_req = halt;
      push(b, ov(0, 0, 0, 0, 0, 0, 1, 1, 0, 3'd5));
    end
    if (halt) begin
      b = rnd(noise); b.halt_req = 1'b1;
      push(b, ov(0, 0, 0, 0, 0, 0, 0, 0, 1, 3'd6));
      b = rnd(noise); b.halt_req = 1'b0;
      push(b, ov(0, 0, 0, 0, 0, 0, 0, 0, 1, 3'd6));
    end
    exp_retired++;
    exp_stall += ifs + ((ld || st) ? dms : 0) + lat - 1;
  endtask

  // Drive queued stimulus one cycle at a time and compare each cycle's outputs.
  task automatic run(input string tag, input int n);
    in_t         b;
    logic [11:0] e;
    for (int k = 0; k < n && stim_q.size() > 0; k++) begin
      @(negedge clk);
      b = stim_q.pop_front();
      apply(b);
      #1;
      e = exp_q.pop_front();
      check($sformatf("%s[%0d]", tag, k), 32'(dut_vec), 32'(e));
    end
  endtask

  initial begin
    reset = 1'b1;
    apply(in_t'(9'd0));
    repeat (2) @(negedge clk);
    #1;
    check("reset_outputs", 32'(dut_vec), 32'd0);
`ifdef STAGE_SEQ_PERF_EN
    check("reset_retired", retired_cnt, 32'd0);
    check("reset_stall", stall_cnt, 32'd0);
`endif
    reset = 1'b0;
    #1;
    check("idle", 32'(dut_vec), 32'd0);

    gen(0, 0, 1, 0, 0, 0, 0, 0, 0, 0); run("add_wb", 1000);
    gen(0, 0, 1, 1, 0, 0, 0, 0, 0, 0); run("mul_wb", 1000);
    gen(1, 0, 0, 0, 0, 0, 0, 2, 0, 0); run("load_dstall", 1000);
    gen(0, 1, 0, 0, 0, 0, 1, 0, 0, 0); run("store_istall", 1000);
    gen(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); run("branch", 1000);
    gen(0, 0, 1, 0, 1, 0, 0, 0, 0, 0); run("div_wb", 1000);
    gen(0, 0, 0, 0, 0, 1, 0, 0, 0, 0); run("mod_nowb", 1000);
    gen(0, 0, 1, 1, 1, 1, 0, 0, 0, 0); run("mul_prio", 1000);
    gen(0, 0, 1, 0, 0, 0, 0, 0, 1, 0); run("halt", 1000);
    gen(0, 1, 1, 0, 0, 0, 2, 1, 0, 1); run("noise_st", 1000);
    gen(1, 0, 1, 0, 0, 0, 1, 3, 0, 1); run("noise_ld", 1000);
    gen(0, 0, 1, 1, 0, 0, 0, 0, 0, 1); run("noise_mul", 1000);
`ifdef STAGE_SEQ_PERF_EN
    @(posedge clk);
    #1;
    check("perf_retired", retired_cnt, 32'(exp_retired));
    check("perf_stall", stall_cnt, 32'(exp_stall));
`endif

    // Load stalled in MEMORY, aborted by an asynchronous reset.
    gen(1, 0, 1, 0, 0, 0, 0, 5, 0, 0); run("ld_abort", 4);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_outputs", 32'(dut_vec), 32'd0);
`ifdef STAGE_SEQ_PERF_EN
    check("async_reset_retired", retired_cnt, 32'd0);
    check("async_reset_stall", stall_cnt, 32'd0);
`endif
    stim_q.delete();
    exp_q.delete();
    exp_retired = 0;
    exp_stall   = 0;
    @(negedge clk);
    #1;
    check("reset_held", 32'(dut_vec), 32'd0);
    reset = 1'b0;
    #1;
    check("idle_after_abort", 32'(dut_vec), 32'd0);
    gen(0, 0, 1, 0, 0, 0, 0, 0, 0, 0); run("add_after_abort", 1000);
`ifdef STAGE_SEQ_PERF_EN
    @(posedge clk);
    #1;
    check("final_retired", retired_cnt, 32'(exp_retired));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/stage_sequencer.md
Name: stage_sequencer

Overview:
- Multi-cycle control FSM that steps the existing single-cycle RISC datapath (IF, OF, EX, MA, RF) through the stages fetch, decode, execute, memory and writeback.
- Drives the stage enables and the register-file write strobe.
- Holds EX for multi-cycle mul/div/mod operations.
- Runs req/ready handshakes with the instruction memory and the data memory.
- Sits between the Processor top level and the stage modules. Instruction-class flags come from OF decode.

Parameters:
- MUL_LAT, 3, EX cycles for isMul (1..255).
- DIV_LAT, 8, EX cycles for isDiv or isMod (1..255).
- ALU_LAT, 1, EX cycles for all other instructions (1..255).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- imem_ready  in  1  instruction memory has valid data this cycle.
- dmem_ready  in  1  data memory access completes this cycle.
- isLd, isSt, isWb, isMul, isDiv, isMod  in  1 each  decode flags, valid in DECODE.
- halt_req  in  1  request to stop at the next instruction boundary.
- imem_req  out  1  fetch request.
- ir_en  out  1  latch instruction register.
- of_en  out  1  operand fetch/decode enable.
- ex_en  out  1  EX stage enable and flag update.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  data memory write (store).
- rf_we  out  1  register-file write strobe (replaces direct isWb).
- pc_en  out  1  PC update; selects branchPC or PC+4.
- halted  out  1  FSM is in HALT.
- state  out  3  current state encoding, for debug.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: reset forces state=IDLE. Latched flags and the counter clear to 0. Every output is 0 while reset is high and in IDLE.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, HALT=6. Encoding 7 is illegal and returns to IDLE on the next edge.
- IDLE: goes to FETCH unconditionally on the first edge after reset is released.
- FETCH:
  - imem_req=1.
  - ir_en = imem_ready (Mealy output).
  - On imem_ready go to DECODE; otherwise stay in FETCH.
- DECODE:
  - of_en=1 for one cycle.
  - Latch isLd, isSt, isWb.
  - Load the counter: MUL_LAT if isMul; else DIV_LAT if isDiv or isMod; else ALU_LAT.
  - Flag priority is isMul > isDiv/isMod > other.
  - Go to EXECUTE.
- EXECUTE:
  - ex_en=1 every cycle.
  - The counter decrements each cycle. The last cycle is the one where counter==1.
  - On the last cycle:
    - latched isLd or isSt → MEMORY;
    - else latched isWb → WRITEBACK;
    - else complete the instruction.
- MEMORY:
  - dmem_req=1; dmem_we = latched isSt.
  - Hold until dmem_ready.
  - On dmem_ready: latched isLd → WRITEBACK; otherwise complete the instruction.
- WRITEBACK: rf_we=1 for one cycle, then complete the instruction.
- Instruction completion: pc_en=1 in that same cycle (Mealy output). Next state is HALT if halt_req=1, else FETCH.
- HALT: all strobes 0, halted=1. Returns to FETCH on the first cycle with halt_req=0.
- Latched flags are used after DECODE. Input flag changes in EXECUTE, MEMORY or WRITEBACK are ignored.
- Minimum latency with memories always ready:
  - ALU with writeback: 4 cycles (F, D, E, W).
  - Compare/branch: 3 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
  - Mul with writeback: 3+MUL_LAT cycles.
- Exactly one pc_en pulse per retired instruction. rf_we and dmem_req never overlap.
- halt_req is ignored mid-instruction. It is only sampled at completion.
- Reset asserted in any state aborts immediately. Stalled handshakes are dropped with no completion pulse.

Optional Feature:
- Macro: STAGE_SEQ_PERF_EN.
- When defined, adds outputs:
  - retired_cnt[31:0]: increments on each pc_en.
  - stall_cnt[31:0]: increments on each cycle with (FETCH and !imem_ready) or (MEMORY and !dmem_ready) or (EXECUTE and counter>1).
  - Both counters reset to 0 and wrap modulo 2^32.
- When undefined, these ports and registers do not exist and behaviour is otherwise identical.

Decomposition:
- Package stage_seq_pkg: the state encoding constants (3-bit) and the latency counter width constant (8).
- One sub-module, ex_latency_counter: load/decrement, with a last-cycle output flag.

Test Plan:
- Reset, then add with isWb=1 and both memories always ready → ir_en at cycle 1, of_en at 2, ex_en at 3, rf_we and pc_en together at 4, then FETCH at 5.
- isMul=1, isWb=1, MUL_LAT=3 → ex_en high for exactly 3 cycles, then rf_we; 6 cycles total.
- Load with dmem_ready held low for 2 cycles → dmem_req high for 3 cycles, dmem_we=0, then rf_we and pc_en once; 7 cycles total.
- Store with imem_ready low for 1 cycle → FETCH lasts 2 cycles, dmem_we=1, no rf_we, pc_en once.
- halt_req raised during EXECUTE of an add → instruction completes with pc_en, then halted=1 and no imem_req. Dropping halt_req gives FETCH on the next cycle.
- reset pulsed mid-MEMORY → all outputs 0 asynchronously, no pc_en; after release IDLE→FETCH. With STAGE_SEQ_PERF_EN, both counters read 0.
